// File: rtl/com_tx_pkg.sv
// Shared opcodes, bus command codes, state enums and word encoding for the MCU command bus transmitter.
// Imported by com_tx and com_tx_pacer; the receiver's decoder uses the same CMD_* codes.
package com_tx_pkg;

    typedef enum logic [2:0] {
        OP_FLIP       = 3'd0,
        OP_COLOR      = 3'd1,
        OP_DOT        = 3'd2,
        OP_POLY_START = 3'd3,
        OP_VERTEX     = 3'd4
    } op_e;

    localparam logic [8:0] CMD_FLIP     = 9'd0;
    localparam logic [8:0] CMD_POLYLINE = 9'd1;
    localparam logic [8:0] CMD_COLOR    = 9'd4;
    localparam logic [8:0] CMD_DOT      = 9'd5;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_DOT  = 2'd1,
        MODE_POLY = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_SETUP = 2'd1,
        P_HI    = 2'd2,
        P_LO    = 2'd3
    } pacer_state_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_ERR  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [8:0] color;
        logic [7:0] x;
        logic [7:0] y;
    } req_t;

    typedef struct packed {
        logic       cmd;
        logic [8:0] dat;
        logic       last;
    } word_t;

    // Word slots: 0 = command word, 1/2 = data words. DOT and VERTEX share the
    // slot layout so a DOT in DOT mode, or a VERTEX, simply starts at slot 1.
    function automatic word_t word_at(input req_t r, input logic [1:0] idx);
        word_t w;
        w = '0;
        case (r.op)
            OP_FLIP: begin
                w.cmd  = 1'b1;
                w.dat  = CMD_FLIP;
                w.last = 1'b1;
            end
            OP_COLOR, OP_POLY_START: begin
                if (idx == 2'd0) begin
                    w.cmd = 1'b1;
                    w.dat = (r.op == OP_COLOR) ? CMD_COLOR : CMD_POLYLINE;
                end else begin
                    w.dat  = r.color;
                    w.last = 1'b1;
                end
            end
            OP_DOT, OP_VERTEX: begin
                case (idx)
                    2'd0: begin
                        w.cmd = 1'b1;
                        w.dat = CMD_DOT;
                    end
                    2'd1: w.dat = {1'b0, r.y};
                    default: begin
                        w.dat  = {1'b0, r.x};
                        w.last = 1'b1;
                    end
                endcase
            end
            default: w.last = 1'b1;
        endcase
        return w;
    endfunction

    function automatic logic [1:0] start_idx(input logic [2:0] op, input mode_e mode);
        logic [1:0] s;
        s = 2'd0;
        if ((op == OP_DOT && mode == MODE_DOT) || op == OP_VERTEX) begin
            s = 2'd1;
        end
        return s;
    endfunction

    function automatic logic is_illegal(input logic [2:0] op, input mode_e mode);
        return (op > OP_VERTEX) || (op == OP_VERTEX && mode != MODE_POLY);
    endfunction

    function automatic mode_e next_mode(input logic [2:0] op, input mode_e mode);
        mode_e m;
        m = mode;
        case (op)
            OP_FLIP:       m = MODE_NONE;
            OP_DOT:        m = MODE_DOT;
            OP_POLY_START: m = MODE_POLY;
            default:       m = mode;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/com_tx_if.sv
// Request handshake plus the 9-bit command bus of the transmitter.
// slave = com_tx side, master = the request source / bus observer.
interface com_tx_if;
    logic       iReqValid;
    logic       oReqReady;
    logic [2:0] iReqOp;
    logic [8:0] iReqColor;
    logic [7:0] iReqX;
    logic [7:0] iReqY;
    logic       iHold;
    logic [8:0] oD;
    logic       oCmd;
    logic       oGo;
    logic       oErr;

    modport slave (
        input  iReqValid, iReqOp, iReqColor, iReqX, iReqY, iHold,
        output oReqReady, oD, oCmd, oGo, oErr
    );

    modport master (
        output iReqValid, iReqOp, iReqColor, iReqX, iReqY, iHold,
        input  oReqReady, oD, oCmd, oGo, oErr
    );
endinterface

// File: rtl/com_tx_pacer.sv
// Paces one bus word: SETUP (word shown) -> HI (GO_HIGH cycles of go) -> LO (GO_LOW cycles).
// Latency 1+GO_HIGH+GO_LOW per word; hold_i stalls only in SETUP; next word accepted on the last LO cycle.
module com_tx_pacer
    import com_tx_pkg::*;
#(
    parameter int GO_HIGH = 4,
    parameter int GO_LOW  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       word_vld_i,
    output logic       word_rdy_o,
    input  logic       word_cmd_i,
    input  logic [8:0] word_dat_i,
    input  logic       hold_i,
    output logic       go_o,
    output logic       cmd_o,
    output logic [8:0] d_o
);

    localparam int TMAX = (GO_HIGH > GO_LOW) ? GO_HIGH : GO_LOW;
    localparam int TW   = $clog2(TMAX + 1);

    pacer_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    d_q, d_d;
    logic          cmd_q, cmd_d;

    assign word_rdy_o = (state_q == P_IDLE) || (state_q == P_LO && timer_q == '0);
    assign go_o       = (state_q == P_HI);
    assign cmd_o      = cmd_q;
    assign d_o        = d_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        d_d     = d_q;
        cmd_d   = cmd_q;
        case (state_q)
            P_IDLE: begin
                if (word_vld_i) begin
                    state_d = P_SETUP;
                    d_d     = word_dat_i;
                    cmd_d   = word_cmd_i;
                end
            end
            P_SETUP: begin
                if (!hold_i) begin
                    state_d = P_HI;
                    timer_d = TW'(GO_HIGH - 1);
                end
            end
            P_HI: begin
                if (timer_q == '0) begin
                    state_d = P_LO;
                    timer_d = TW'(GO_LOW - 1);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            P_LO: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (word_vld_i) begin
                    // Back-to-back words: the bus only changes on SETUP entry.
                    state_d = P_SETUP;
                    d_d     = word_dat_i;
                    cmd_d   = word_cmd_i;
                end else begin
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= P_IDLE;
            timer_q <= '0;
            d_q     <= '0;
            cmd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            d_q     <= d_d;
            cmd_q   <= cmd_d;
        end
    end

endmodule

// File: rtl/com_tx.sv
// MCU command bus transmitter: expands draw requests into paced command/data words.
// First word in SETUP one cycle after accept; request ready only when idle; dropped requests pulse oErr.
module com_tx
    import com_tx_pkg::*;
#(
    parameter int GO_HIGH = 4,
    parameter int GO_LOW  = 4
) (
    input  logic     iClk,
    input  logic     iRst,
    com_tx_if.slave  bus
);

    seq_state_e state_q, state_d;
    mode_e      mode_q, mode_d;
    req_t       req_q, req_d;
    logic [1:0] idx_q, idx_d;

    req_t       req_live;
    req_t       src;
    logic [1:0] src_idx;
    word_t      word;
    logic       illegal;
    logic       word_vld;
    logic       word_rdy;

    assign req_live = '{op: bus.iReqOp, color: bus.iReqColor, x: bus.iReqX, y: bus.iReqY};

    // In IDLE the first word comes straight from the bus so it is in SETUP one cycle after accept.
    assign src     = (state_q == S_IDLE) ? req_live : req_q;
    assign src_idx = (state_q == S_IDLE) ? start_idx(bus.iReqOp, mode_q) : idx_q;
    assign word    = word_at(src, src_idx);
    assign illegal = is_illegal(bus.iReqOp, mode_q);

    assign bus.oReqReady = (state_q == S_IDLE);
    assign bus.oErr      = (state_q == S_ERR);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        req_d    = req_q;
        idx_d    = idx_q;
        word_vld = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.iReqValid) begin
                    req_d = req_live;
                    if (illegal) begin
                        state_d = S_ERR;
                    end else begin
                        word_vld = 1'b1;
                        mode_d   = next_mode(bus.iReqOp, mode_q);
                        idx_d    = src_idx + 2'd1;
                        state_d  = word.last ? S_WAIT : S_SEND;
                    end
                end
            end
            S_SEND: begin
                word_vld = 1'b1;
                if (word_rdy) begin
                    idx_d = idx_q + 2'd1;
                    if (word.last) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (word_rdy) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_NONE;
            req_q   <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
        end
    end

    com_tx_pacer #(
        .GO_HIGH (GO_HIGH),
        .GO_LOW  (GO_LOW)
    ) u_pacer (
        .clk_i      (iClk),
        .rst_i      (iRst),
        .word_vld_i (word_vld),
        .word_rdy_o (word_rdy),
        .word_cmd_i (word.cmd),
        .word_dat_i (word.dat),
        .hold_i     (bus.iHold),
        .go_o       (bus.oGo),
        .cmd_o      (bus.oCmd),
        .d_o        (bus.oD)
    );

endmodule
